// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and types for the multi-port register file
// Purpose : default geometry of the register file and the bypass-source encoding
//           used by every read port.
// Ports   : none (package)
package regfile_mp_pkg;

  localparam int DEFAULT_DATA_W   = 64;
  localparam int DEFAULT_DEPTH    = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_NUM_RD   = 2;
  localparam int DEFAULT_ZERO_REG = 31;

  // Which source a read port forwards from in the current cycle.
  typedef enum logic [1:0] {
    BYP_NONE = 2'd0,
    BYP_P0   = 2'd1,
    BYP_P1   = 2'd2
  } bypSel_e;

  // A zero register index equal to DEPTH (or beyond) disables the feature.
  function automatic bit zeroRegEnabled(int zeroReg, int depth);
    return zeroReg < depth;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/issue bus of the multi-port register file
// Purpose : bundles the decode-side read ports, the two writeback ports and the
//           scoreboard issue port.
// Ports   : master = decode/writeback side (drives addresses, write data, issue)
//           slave  = register file (drives BusR, Busy)
//   RA      NUM_RD*ADDR_W  read addresses, port k at RA[k*ADDR_W +: ADDR_W]
//   BusR    NUM_RD*DATA_W  read data, port k at BusR[k*DATA_W +: DATA_W]
//   RW0/1   ADDR_W         write addresses
//   BusW0/1 DATA_W         write data
//   RegWr0/1               write enables
//   IssueWr, IssueRd       scoreboard: mark IssueRd pending
//   Busy    NUM_RD         scoreboard: read port k addresses a pending register
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] RA;
  logic [NUM_RD*DATA_W-1:0] BusR;
  logic [ADDR_W-1:0]        RW0;
  logic [DATA_W-1:0]        BusW0;
  logic                     RegWr0;
  logic [ADDR_W-1:0]        RW1;
  logic [DATA_W-1:0]        BusW1;
  logic                     RegWr1;
  logic                     IssueWr;
  logic [ADDR_W-1:0]        IssueRd;
  logic [NUM_RD-1:0]        Busy;

  modport master (
    output RA, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, IssueWr, IssueRd,
    input  BusR, Busy
  );

  modport slave (
    input  RA, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, IssueWr, IssueRd,
    output BusR, Busy
  );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with zero check and bypass
// Purpose : selects between stored data, same-cycle write data (port 1 over
//           port 0) and the hardwired zero, and qualifies the pending bit.
// Ports   : ra          read address
//           stored      array contents at ra
//           pendingBit  scoreboard pending flag for ra (0 when scoreboard absent)
//           regWr0/1, rw0/1, busW0/1  current-cycle write ports
//           busR        read data
//           busy        ra is pending and not satisfied by a bypass
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter bit                ZERO_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] ZERO_ADDR = '0
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              pendingBit,
  input  logic              regWr0,
  input  logic [ADDR_W-1:0] rw0,
  input  logic [DATA_W-1:0] busW0,
  input  logic              regWr1,
  input  logic [ADDR_W-1:0] rw1,
  input  logic [DATA_W-1:0] busW1,
  output logic [DATA_W-1:0] busR,
  output logic              busy
);

  logic    isZero;
  bypSel_e sel;

  always_comb begin
    isZero = ZERO_EN && (ra == ZERO_ADDR);
    sel    = BYP_NONE;
    // Port 1 is checked first so forwarding agrees with the write-collision rule.
    if (!isZero) begin
      if (regWr1 && (rw1 == ra)) begin
        sel = BYP_P1;
      end else if (regWr0 && (rw0 == ra)) begin
        sel = BYP_P0;
      end
    end

    case (sel)
      BYP_P1:  busR = busW1;
      BYP_P0:  busR = busW0;
      default: busR = isZero ? '0 : stored;
    endcase

    // A bypass hit delivers the value now, so the consumer need not stall.
    busy = pendingBit && (sel == BYP_NONE) && !isZero;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass
// Purpose : NUM_RD combinational read ports, two clocked write ports (port 1
//           wins on collision), optional hardwired-zero register, write-to-read
//           bypass. Optional scoreboard enabled by defining SCOREBOARD_EN.
// Ports   : CLK     rising-edge clock
//           Resetn  asynchronous active-low reset, clears array and pending
//           bus     regfile_mp_if.slave (RA/BusR, RW*/BusW*/RegWr*, IssueWr/IssueRd, Busy)
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic         CLK,
  input  logic         Resetn,
  regfile_mp_if.slave  bus
);

  localparam bit                ZERO_EN   = zeroRegEnabled(ZERO_REG, DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_EN ? ADDR_W'(ZERO_REG) : '0;

  logic [DATA_W-1:0] regs [DEPTH];

  logic wrEn0, wrEn1;

  assign wrEn1 = bus.RegWr1 && !(ZERO_EN && (bus.RW1 == ZERO_ADDR));
  // Port 0 is dropped whenever port 1 targets the same register this cycle.
  assign wrEn0 = bus.RegWr0 && !(ZERO_EN && (bus.RW0 == ZERO_ADDR))
               && !(bus.RegWr1 && (bus.RW1 == bus.RW0));

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wrEn0) regs[bus.RW0] <= bus.BusW0;
      if (wrEn1) regs[bus.RW1] <= bus.BusW1;
    end
  end

`ifdef SCOREBOARD_EN
  logic [DEPTH-1:0] pending;

  // Clears first, then the issue set, so a new producer overrides a
  // same-cycle completion on the same register.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      pending <= '0;
    end else begin
      if (bus.RegWr0) pending[bus.RW0] <= 1'b0;
      if (bus.RegWr1) pending[bus.RW1] <= 1'b0;
      if (bus.IssueWr && !(ZERO_EN && (bus.IssueRd == ZERO_ADDR))) begin
        pending[bus.IssueRd] <= 1'b1;
      end
    end
  end

  assert property (@(posedge CLK) disable iff (!Resetn)
    bus.IssueWr |-> (int'(bus.IssueRd) < DEPTH));
`else
  logic unusedIssue;
  assign unusedIssue = ^{bus.IssueWr, bus.IssueRd};
`endif

  logic [NUM_RD*DATA_W-1:0] busR;
  logic [NUM_RD-1:0]        busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] ra;
    logic              pendingBit;

    assign ra = bus.RA[k*ADDR_W +: ADDR_W];
`ifdef SCOREBOARD_EN
    assign pendingBit = pending[ra];
`else
    assign pendingBit = 1'b0;
`endif

    regfile_rd_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .ZERO_EN   (ZERO_EN),
      .ZERO_ADDR (ZERO_ADDR)
    ) uRdPort (
      .ra         (ra),
      .stored     (regs[ra]),
      .pendingBit (pendingBit),
      .regWr0     (bus.RegWr0),
      .rw0        (bus.RW0),
      .busW0      (bus.BusW0),
      .regWr1     (bus.RegWr1),
      .rw1        (bus.RW1),
      .busW1      (bus.BusW1),
      .busR       (busR[k*DATA_W +: DATA_W]),
      .busy       (busy[k])
    );

    assert property (@(posedge CLK) disable iff (!Resetn) int'(ra) < DEPTH);
  end

  assign bus.BusR = busR;
  assign bus.Busy = busy;

  assert property (@(posedge CLK) disable iff (!Resetn)
    bus.RegWr0 |-> (int'(bus.RW0) < DEPTH));
  assert property (@(posedge CLK) disable iff (!Resetn)
    bus.RegWr1 |-> (int'(bus.RW1) < DEPTH));

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (4 read ports, SCOREBOARD_EN aware)
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 4;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    logic        busy;
  } exp_t;

  logic CLK;
  logic Resetn;
  int   checks = 0;
  int   errors = 0;

  exp_t  expQ[$];
  string nameQ[$];

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(31)
  ) dut (
    .CLK    (CLK),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: at every falling edge compare every expectation queued this cycle.
  always @(negedge CLK) begin
    while (expQ.size() > 0) begin
      exp_t e;
      string n;
      logic [DW-1:0] got;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      got = bus.BusR[e.port*DW +: DW];
      checks++;
      if (got !== e.data) begin
        errors++;
        $display("FAIL %s data port%0d got %h required %h", n, e.port, got, e.data);
      end
      checks++;
      if (bus.Busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s busy port%0d got %b required %b", n, e.port, bus.Busy[e.port], e.busy);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    bus.RegWr0  = 1'b0;
    bus.RegWr1  = 1'b0;
    bus.IssueWr = 1'b0;
  endtask

  task automatic setRa(input int k, input logic [AW-1:0] a);
    bus.RA[k*AW +: AW] = a;
  endtask

  task automatic expectRd(input string n, input int port, input logic [DW-1:0] d, input logic b);
    exp_t e;
    e.port = port;
    e.data = d;
    e.busy = b;
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.RegWr0 = 1'b1; bus.RW0 = a; bus.BusW0 = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.RegWr1 = 1'b1; bus.RW1 = a; bus.BusW1 = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn      = 1'b0;
    bus.RA      = '0;
    bus.RW0     = '0; bus.BusW0 = '0; bus.RegWr0 = 1'b0;
    bus.RW1     = '0; bus.BusW1 = '0; bus.RegWr1 = 1'b0;
    bus.IssueWr = 1'b0; bus.IssueRd = '0;

    // Reset state
    setRa(0, 5'd0); setRa(1, 5'd5); setRa(2, 5'd7); setRa(3, 5'd31);
    for (int k = 0; k < NR; k++) expectRd("reset_init", k, '0, 1'b0);
    step();
    step();
    Resetn = 1'b1;

    // Bypass on write then stored read
    step();
    wr0(5'd5, 64'hDEAD); setRa(0, 5'd5);
    expectRd("bypass_p0", 0, 64'hDEAD, 1'b0);
    step();
    expectRd("stored_5", 0, 64'hDEAD, 1'b0);

    // Hardwired zero register ignores writes and bypass
    step();
    wr0(5'd31, 64'h1); setRa(0, 5'd31);
    expectRd("zero_wcycle", 0, '0, 1'b0);
    step();
    expectRd("zero_next", 0, '0, 1'b0);

    // Same-address dual write, port 1 wins
    step();
    wr0(5'd7, 64'h11); wr1(5'd7, 64'h22); setRa(0, 5'd7); setRa(1, 5'd7);
    expectRd("dual_same_p0", 0, 64'h22, 1'b0);
    expectRd("dual_same_p1", 1, 64'h22, 1'b0);
    step();
    expectRd("dual_after", 0, 64'h22, 1'b0);

    // Independent bypass from both write ports
    step();
    wr0(5'd8, 64'h88); wr1(5'd9, 64'h99); setRa(0, 5'd8); setRa(1, 5'd9); setRa(2, 5'd5);
    expectRd("byp_split0", 0, 64'h88, 1'b0);
    expectRd("byp_split1", 1, 64'h99, 1'b0);
    expectRd("byp_stored5", 2, 64'hDEAD, 1'b0);

    // Four ports read four registers in one cycle
    step();
    wr0(5'd1, 64'h101); wr1(5'd2, 64'h202);
    step();
    wr0(5'd3, 64'h303); wr1(5'd4, 64'h404);
    step();
    setRa(0, 5'd1); setRa(1, 5'd2); setRa(2, 5'd3); setRa(3, 5'd4);
    expectRd("four_p0", 0, 64'h101, 1'b0);
    expectRd("four_p1", 1, 64'h202, 1'b0);
    expectRd("four_p2", 2, 64'h303, 1'b0);
    expectRd("four_p3", 3, 64'h404, 1'b0);

    // Mid-run reset with a pending destination outstanding
    step();
    bus.IssueWr = 1'b1; bus.IssueRd = 5'd6;
    step();
    Resetn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NR; k++) begin
        setRa(k, AW'(c*NR + k));
        expectRd("reset_mid", k, '0, 1'b0);
      end
      step();
    end
    Resetn = 1'b1;

`ifdef SCOREBOARD_EN
    step();
    bus.IssueWr = 1'b1; bus.IssueRd = 5'd3;
    step();
    setRa(0, 5'd3);
    expectRd("sb_pending", 0, '0, 1'b1);
    step();
    wr1(5'd3, 64'h33);
    expectRd("sb_bypass_clear", 0, 64'h33, 1'b0);
    step();
    expectRd("sb_cleared", 0, 64'h33, 1'b0);
    step();
    bus.IssueWr = 1'b1; bus.IssueRd = 5'd3; wr0(5'd3, 64'h44);
    step();
    expectRd("sb_set_wins", 0, 64'h44, 1'b1);
    step();
    bus.IssueWr = 1'b1; bus.IssueRd = 5'd31;
    step();
    setRa(1, 5'd31);
    expectRd("sb_zero_never", 1, '0, 1'b0);
`else
    step();
    bus.IssueWr = 1'b1; bus.IssueRd = 5'd3;
    step();
    setRa(0, 5'd3);
    expectRd("noscb_busy0", 0, '0, 1'b0);
`endif

    step();
    step();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain queue size got %0d required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
